// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Bundle between the instruction-fetch stage, the unified memory read port
// and the controller/datapath of the multicycle RV32I core.
//   master : controller/memory side (drives fetch requests and read data,
//            consumes the captured instruction, stall and counters)
//   slave  : fetch_unit side
// Signals
//   IRWrite, PCWrite_in, PC, ReadData, mem_ready : requests / memory return
//   PCWrite, Stall                               : gated controls back out
//   Instr, OldPC, Data                           : architectural registers
//   op, funct3, funct7b5, rs1, rs2, rd           : decoded Instr fields
//   fetch_err, fetch_cnt, stall_cnt              : status and counters
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int XLEN = 32,
  parameter int CNTW = 32
);
  logic            IRWrite;
  logic            PCWrite_in;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] ReadData;
  logic            mem_ready;

  logic            PCWrite;
  logic            Stall;
  logic [XLEN-1:0] Instr;
  logic [XLEN-1:0] OldPC;
  logic [XLEN-1:0] Data;
  logic [6:0]      op;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic            fetch_err;
  logic [CNTW-1:0] fetch_cnt;
  logic [CNTW-1:0] stall_cnt;

  modport master (
    output IRWrite, PCWrite_in, PC, ReadData, mem_ready,
    input  PCWrite, Stall, Instr, OldPC, Data, op, funct3, funct7b5,
           rs1, rs2, rd, fetch_err, fetch_cnt, stall_cnt
  );

  modport slave (
    input  IRWrite, PCWrite_in, PC, ReadData, mem_ready,
    output PCWrite, Stall, Instr, OldPC, Data, op, funct3, funct7b5,
           rs1, rs2, rd, fetch_err, fetch_cnt, stall_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage of the multicycle RV32I core. Owns the instruction
// register (Instr), the PC of that instruction (OldPC) and the memory data
// register (Data). Holds the controller via Stall while a variable-latency
// memory has not yet returned the instruction word, and raises a sticky
// fetch_err when the wait exceeds TIMEOUT cycles.
// Ports
//   clk    : core clock
//   reset  : synchronous, active-high reset
//   bus    : fetch_unit_if.slave (see interface header for signal list)
// Parameters
//   XLEN    : datapath width
//   TIMEOUT : stall cycles before a pending fetch is declared failed (2..255)
//   CNTW    : width of the saturating performance counters
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 32
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
  localparam logic [7:0]      WCNT_LAST = 8'(TIMEOUT - 1);

  state_t          r_state;
  logic [7:0]      r_wcnt;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_old_pc;
  logic [XLEN-1:0] r_data;
  logic [CNTW-1:0] r_fetch_cnt;
  logic [CNTW-1:0] r_stall_cnt;
  logic            r_fetch_err;
  logic            w_stall;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wcnt      <= 8'd0;
      r_instr     <= NOP_INSTR;
      r_old_pc    <= '0;
      r_data      <= '0;
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      // Data accesses are single-cycle, so the data register just tracks
      // the read port every cycle regardless of fetch state.
      r_data <= bus.ReadData;
      case (r_state)
        S_IDLE: begin
          if (bus.IRWrite) begin
            if (bus.mem_ready) begin
              r_instr     <= bus.ReadData;
              r_old_pc    <= bus.PC;
              r_fetch_cnt <= sat_inc(r_fetch_cnt);
            end else begin
              r_state     <= S_WAIT;
              r_wcnt      <= 8'd1;
              r_stall_cnt <= sat_inc(r_stall_cnt);
            end
          end
        end
        S_WAIT: begin
          if (!bus.IRWrite) begin
            // Controller abandoned the fetch: drop it without capturing.
            r_state <= S_IDLE;
          end else if (bus.mem_ready) begin
            r_instr     <= bus.ReadData;
            r_old_pc    <= bus.PC;
            r_fetch_cnt <= sat_inc(r_fetch_cnt);
            r_state     <= S_IDLE;
          end else begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
            r_wcnt      <= r_wcnt + 8'd1;
            // The IDLE cycle counted as stall #1, so reaching TIMEOUT-1 here
            // means this is stall cycle number TIMEOUT.
            if (r_wcnt == WCNT_LAST) begin
              r_state     <= S_ERR;
              r_fetch_err <= 1'b1;
            end
          end
        end
        S_ERR: begin
          r_state <= S_ERR;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE:  w_stall = bus.IRWrite & ~bus.mem_ready;
      S_WAIT:  w_stall = bus.IRWrite & ~bus.mem_ready;
      S_ERR:   w_stall = 1'b1;
      default: w_stall = 1'b0;
    endcase
  end

  assign bus.Stall     = w_stall;
  // Blocks the PC+4 update while the fetch it belongs to is still pending.
  assign bus.PCWrite   = bus.PCWrite_in & ~w_stall;
  assign bus.Instr     = r_instr;
  assign bus.OldPC     = r_old_pc;
  assign bus.Data      = r_data;
  assign bus.op        = r_instr[6:0];
  assign bus.funct3    = r_instr[14:12];
  assign bus.funct7b5  = r_instr[30];
  assign bus.rs1       = r_instr[19:15];
  assign bus.rs2       = r_instr[24:20];
  assign bus.rd        = r_instr[11:7];
  assign bus.fetch_err = r_fetch_err;
  assign bus.fetch_cnt = r_fetch_cnt;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. Expected instruction/PC pairs are
// queued when a fetch is issued and compared when the capture appears.
// A second instance with CNTW=4 exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errs  = 0;
  int   checks = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  fetch_unit_if #(.XLEN(32), .CNTW(32)) bus ();
  fetch_unit_if #(.XLEN(32), .CNTW(4))  sbus ();

  fetch_unit #(.XLEN(32), .TIMEOUT(16), .CNTW(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fetch_unit #(.XLEN(32), .TIMEOUT(16), .CNTW(4)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.IRWrite = 1'b0;  bus.mem_ready = 1'b0;  bus.PCWrite_in = 1'b0;
    sbus.IRWrite = 1'b0; sbus.mem_ready = 1'b0; sbus.PCWrite_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.IRWrite = 1'b0; bus.mem_ready = 1'b1; bus.PCWrite_in = 1'b1;
    bus.PC = 32'h0; bus.ReadData = 32'hCAFE_0001;
    sbus.IRWrite = 1'b0; sbus.mem_ready = 1'b0; sbus.PCWrite_in = 1'b0;
    sbus.PC = 32'h0; sbus.ReadData = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.Instr !== 32'h0000_0013) begin errs++; $display("FAIL reset_instr got=%h exp=%h", bus.Instr, 32'h13); end
    checks++; if (bus.op !== 7'h13) begin errs++; $display("FAIL reset_op got=%h exp=13", bus.op); end
    checks++; if (bus.OldPC !== 32'h0) begin errs++; $display("FAIL reset_oldpc got=%h exp=0", bus.OldPC); end
    checks++; if (bus.Data !== 32'h0) begin errs++; $display("FAIL reset_data got=%h exp=0", bus.Data); end
    checks++; if (bus.fetch_err !== 1'b0) begin errs++; $display("FAIL reset_fetch_err got=%b exp=0", bus.fetch_err); end
    checks++; if (bus.Stall !== 1'b0 || bus.PCWrite !== 1'b1) begin errs++; $display("FAIL reset_stall_pcwrite got=%b%b exp=01", bus.Stall, bus.PCWrite); end
    checks++; if (bus.fetch_cnt !== 32'd0 || bus.stall_cnt !== 32'd0) begin errs++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.fetch_cnt, bus.stall_cnt); end
  endtask

  task automatic test_zero_wait();
    @(negedge clk);
    bus.PC = 32'h100; bus.ReadData = 32'h0050_0093;
    bus.IRWrite = 1'b1; bus.mem_ready = 1'b1; bus.PCWrite_in = 1'b1;
    #1;
    checks++; if (bus.Stall !== 1'b0 || bus.PCWrite !== 1'b1) begin errs++; $display("FAIL zw_stall_pcwrite got=%b%b exp=01", bus.Stall, bus.PCWrite); end
    e.instr = 32'h0050_0093; e.pc = 32'h100; sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin checks++; errs++; $display("FAIL zw_scoreboard_empty got=0 exp=1"); end
    else begin
      e = sb.pop_front();
      checks++; if (bus.Instr !== e.instr || bus.OldPC !== e.pc) begin errs++; $display("FAIL zw_capture got=%h@%h exp=%h@%h", bus.Instr, bus.OldPC, e.instr, e.pc); end
      checks++; if (bus.rd !== e.instr[11:7] || bus.op !== e.instr[6:0]) begin errs++; $display("FAIL zw_fields got rd=%0d op=%h exp rd=%0d op=%h", bus.rd, bus.op, e.instr[11:7], e.instr[6:0]); end
    end
    checks++; if (bus.fetch_cnt !== 32'd1) begin errs++; $display("FAIL zw_fetch_cnt got=%0d exp=1", bus.fetch_cnt); end
    checks++; if (bus.Data !== 32'h0050_0093) begin errs++; $display("FAIL zw_data got=%h exp=00500093", bus.Data); end
    @(negedge clk);
    bus.IRWrite = 1'b0; bus.mem_ready = 1'b0;
  endtask

  task automatic test_wait3();
    do_reset();
    bus.PCWrite_in = 1'b1;
    bus.PC = 32'h104; bus.ReadData = 32'hDEAD_BEEF;
    bus.IRWrite = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.Stall !== 1'b1 || bus.PCWrite !== 1'b0) begin errs++; $display("FAIL w3_stall_cycle%0d got=%b%b exp=10", i, bus.Stall, bus.PCWrite); end
      @(negedge clk);
    end
    bus.ReadData = 32'h00A0_0113; bus.mem_ready = 1'b1;
    #1;
    checks++; if (bus.Stall !== 1'b0 || bus.PCWrite !== 1'b1) begin errs++; $display("FAIL w3_release got=%b%b exp=01", bus.Stall, bus.PCWrite); end
    e.instr = 32'h00A0_0113; e.pc = 32'h104; sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin checks++; errs++; $display("FAIL w3_scoreboard_empty got=0 exp=1"); end
    else begin
      e = sb.pop_front();
      checks++; if (bus.Instr !== e.instr || bus.OldPC !== e.pc) begin errs++; $display("FAIL w3_capture got=%h@%h exp=%h@%h", bus.Instr, bus.OldPC, e.instr, e.pc); end
    end
    checks++; if (bus.stall_cnt !== 32'd3 || bus.fetch_cnt !== 32'd1) begin errs++; $display("FAIL w3_counters got=%0d/%0d exp=3/1", bus.stall_cnt, bus.fetch_cnt); end
    @(negedge clk);
    bus.IRWrite = 1'b0; bus.mem_ready = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    bus.PCWrite_in = 1'b1;
    bus.PC = 32'h200; bus.ReadData = 32'h1234_5678;
    bus.IRWrite = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if (bus.Stall !== 1'b1 || bus.fetch_err !== 1'b0) begin errs++; $display("FAIL to_pending_cycle%0d got stall=%b err=%b exp stall=1 err=0", i, bus.Stall, bus.fetch_err); end
      @(negedge clk);
    end
    #1;
    checks++; if (bus.fetch_err !== 1'b1) begin errs++; $display("FAIL to_fetch_err got=%b exp=1", bus.fetch_err); end
    checks++; if (bus.stall_cnt !== 32'd16) begin errs++; $display("FAIL to_stall_cnt got=%0d exp=16", bus.stall_cnt); end
    bus.ReadData = 32'h0010_0093; bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.Stall !== 1'b1 || bus.PCWrite !== 1'b0) begin errs++; $display("FAIL to_err_stall%0d got=%b%b exp=10", i, bus.Stall, bus.PCWrite); end
      @(posedge clk); #1;
      checks++; if (bus.Instr !== 32'h0000_0013 || bus.fetch_cnt !== 32'd0 || bus.stall_cnt !== 32'd16) begin errs++; $display("FAIL to_err_frozen%0d got instr=%h fc=%0d sc=%0d exp instr=00000013 fc=0 sc=16", i, bus.Instr, bus.fetch_cnt, bus.stall_cnt); end
      @(negedge clk);
    end
    bus.IRWrite = 1'b0;
    #1;
    checks++; if (bus.Stall !== 1'b1) begin errs++; $display("FAIL to_err_stall_irw0 got=%b exp=1", bus.Stall); end
    do_reset();
    #1;
    checks++; if (bus.fetch_err !== 1'b0 || bus.stall_cnt !== 32'd0 || bus.Stall !== 1'b0) begin errs++; $display("FAIL to_reset_clear got err=%b sc=%0d stall=%b exp 0/0/0", bus.fetch_err, bus.stall_cnt, bus.Stall); end
  endtask

  task automatic test_irwrite_drop();
    do_reset();
    bus.PCWrite_in = 1'b1;
    bus.PC = 32'h300; bus.ReadData = 32'h0030_0193;
    bus.IRWrite = 1'b1; bus.mem_ready = 1'b1;
    e.instr = 32'h0030_0193; e.pc = 32'h300; sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin checks++; errs++; $display("FAIL drop_scoreboard_empty got=0 exp=1"); end
    else begin
      e = sb.pop_front();
      checks++; if (bus.Instr !== e.instr || bus.OldPC !== e.pc) begin errs++; $display("FAIL drop_first_capture got=%h@%h exp=%h@%h", bus.Instr, bus.OldPC, e.instr, e.pc); end
    end
    @(negedge clk);
    bus.PC = 32'h304; bus.ReadData = 32'h0000_0BAD; bus.mem_ready = 1'b0;
    #1;
    checks++; if (bus.Stall !== 1'b1) begin errs++; $display("FAIL drop_enter_wait got=%b exp=1", bus.Stall); end
    @(negedge clk);
    bus.IRWrite = 1'b0; bus.mem_ready = 1'b1; bus.ReadData = 32'h0040_0213;
    #1;
    checks++; if (bus.Stall !== 1'b0 || bus.PCWrite !== 1'b1) begin errs++; $display("FAIL drop_stall got=%b%b exp=01", bus.Stall, bus.PCWrite); end
    @(posedge clk); #1;
    checks++; if (bus.Instr !== 32'h0030_0193 || bus.OldPC !== 32'h300) begin errs++; $display("FAIL drop_no_capture got=%h@%h exp=00300193@00000300", bus.Instr, bus.OldPC); end
    checks++; if (bus.fetch_cnt !== 32'd1 || bus.stall_cnt !== 32'd1) begin errs++; $display("FAIL drop_counters got=%0d/%0d exp=1/1", bus.fetch_cnt, bus.stall_cnt); end
    checks++; if (bus.Data !== 32'h0040_0213 || bus.fetch_err !== 1'b0) begin errs++; $display("FAIL drop_data_only got data=%h err=%b exp 00400213/0", bus.Data, bus.fetch_err); end
    @(negedge clk);
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int waits;
    do_reset();
    bus.PCWrite_in = 1'b1;
    bus.IRWrite = 1'b1;
    for (int n = 0; n < 8; n++) begin
      waits = n % 3;
      bus.PC = 32'h400 + 32'(4 * n);
      bus.ReadData = 32'hFFFF_FFFF;
      bus.mem_ready = 1'b0;
      for (int w = 0; w < waits; w++) begin
        #1;
        checks++; if (bus.Stall !== 1'b1) begin errs++; $display("FAIL b2b_stall n=%0d w=%0d got=%b exp=1", n, w, bus.Stall); end
        @(negedge clk);
      end
      e.instr = (n == 0) ? 32'h40B5_0533 : $urandom;
      e.pc = bus.PC;
      bus.ReadData = e.instr;
      bus.mem_ready = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1;
      if (sb.size() == 0) begin checks++; errs++; $display("FAIL b2b_scoreboard_empty n=%0d got=0 exp=1", n); end
      else begin
        e = sb.pop_front();
        checks++; if (bus.Instr !== e.instr || bus.OldPC !== e.pc) begin errs++; $display("FAIL b2b_capture n=%0d got=%h@%h exp=%h@%h", n, bus.Instr, bus.OldPC, e.instr, e.pc); end
        checks++;
        if (bus.op !== e.instr[6:0] || bus.funct3 !== e.instr[14:12] || bus.funct7b5 !== e.instr[30] ||
            bus.rs1 !== e.instr[19:15] || bus.rs2 !== e.instr[24:20] || bus.rd !== e.instr[11:7]) begin
          errs++;
          $display("FAIL b2b_fields n=%0d got op=%h f3=%h f7=%b rs1=%0d rs2=%0d rd=%0d exp op=%h f3=%h f7=%b rs1=%0d rs2=%0d rd=%0d",
                   n, bus.op, bus.funct3, bus.funct7b5, bus.rs1, bus.rs2, bus.rd,
                   e.instr[6:0], e.instr[14:12], e.instr[30], e.instr[19:15], e.instr[24:20], e.instr[11:7]);
        end
      end
      @(negedge clk);
    end
    bus.IRWrite = 1'b0; bus.mem_ready = 1'b0;
    #1;
    checks++; if (bus.fetch_cnt !== 32'd8 || bus.stall_cnt !== 32'd7) begin errs++; $display("FAIL b2b_counters got=%0d/%0d exp=8/7", bus.fetch_cnt, bus.stall_cnt); end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_cnt;
    do_reset();
    sbus.IRWrite = 1'b1; sbus.mem_ready = 1'b1; sbus.PCWrite_in = 1'b1;
    for (int n = 0; n < 20; n++) begin
      sbus.PC = 32'(4 * n);
      sbus.ReadData = $urandom;
      exp_cnt = (n + 1 >= 15) ? 4'hF : 4'(n + 1);
      @(posedge clk); #1;
      checks++; if (sbus.fetch_cnt !== exp_cnt) begin errs++; $display("FAIL sat_fetch_cnt n=%0d got=%h exp=%h", n, sbus.fetch_cnt, exp_cnt); end
      @(negedge clk);
    end
    sbus.IRWrite = 1'b0; sbus.mem_ready = 1'b0;
  endtask

  initial begin
    bus.IRWrite = 1'b0; bus.PCWrite_in = 1'b0; bus.PC = '0; bus.ReadData = '0; bus.mem_ready = 1'b0;
    sbus.IRWrite = 1'b0; sbus.PCWrite_in = 1'b0; sbus.PC = '0; sbus.ReadData = '0; sbus.mem_ready = 1'b0;
    test_reset();
    test_zero_wait();
    test_wait3();
    test_timeout();
    test_irwrite_drop();
    test_back_to_back();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the multicycle RV32I core. It sits directly upstream of the controller, between the unified memory read port and the controller/datapath. It owns the instruction register (Instr), the OldPC register and the memory data register (Data), and supplies op/funct3/funct7b5 and register fields to the controller. It also stalls the controller while a variable-latency memory has not returned the instruction word, and flags a fetch timeout.

## Interface
- XLEN, 32: datapath width
- TIMEOUT, 16: wait cycles before a pending fetch is declared failed (2..255)
- CNTW, 32: width of performance counters
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- IRWrite  in  1  controller requests instruction capture (Fetch state)
- PCWrite_in  in  1  PC write enable from controller
- PC  in  XLEN  current PC (fetch address)
- ReadData  in  XLEN  memory read data
- mem_ready  in  1  memory read data valid this cycle
- PCWrite  out  1  gated PC write enable to datapath
- Stall  out  1  controller must hold its state while high
- Instr  out  XLEN  instruction register
- OldPC  out  XLEN  PC of instruction in Instr
- Data  out  XLEN  memory data register
- op  out  7  Instr[6:0]
- funct3  out  3  Instr[14:12]
- funct7b5  out  1  Instr[30]
- rs1, rs2, rd  out  5 each  Instr[19:15], Instr[24:20], Instr[11:7]
- fetch_err  out  1  sticky fetch-timeout flag
- fetch_cnt, stall_cnt  out  CNTW each  completed fetches / stall cycles

## Operation
- States: IDLE, WAIT, ERR. Internal wait counter wcnt, 8 bits.
- IDLE: if IRWrite & mem_ready: Instr<=ReadData, OldPC<=PC, fetch_cnt++, stay IDLE. If IRWrite & ~mem_ready: go WAIT, wcnt<=1, stall_cnt++. Else hold.
- WAIT: if ~IRWrite (protocol violation): go IDLE, no capture. Else if mem_ready: capture as above, fetch_cnt++, go IDLE. Else stall_cnt++, wcnt++; if wcnt==TIMEOUT-1 before increment, go ERR.
- ERR: no captures, no counting; remains until reset.
- Stall (combinational): IDLE: IRWrite & ~mem_ready; WAIT: IRWrite & ~mem_ready; ERR: 1.
- PCWrite = PCWrite_in & ~Stall (combinational). Prevents PC+4 update during a stalled Fetch.
- fetch_err = (state==ERR).
- Data <= ReadData every cycle, independent of state; data accesses are single-cycle.
- Decoded fields are pure slices of the registered Instr.
- Counters saturate at all-ones; no wrap.

## Timing
- Reset (synchronous, takes priority over all events): state IDLE, Instr=32'h00000013 (nop), OldPC=0, Data=0, wcnt=0, counters=0, fetch_err=0. Stall/PCWrite follow their equations from inputs immediately after reset.
- Zero-wait fetch: IRWrite & mem_ready in cycle N → Instr/OldPC valid from cycle N+1, Stall low in N.
- k-wait fetch (mem_ready first high in cycle N+k): Stall high in cycles N..N+k-1, low in N+k; capture at end of N+k; stall_cnt += k.
- Timeout: with mem_ready held low, ERR entered after TIMEOUT stall cycles; fetch_err high from then on; a late mem_ready does not capture.
- mem_ready high while IRWrite low: no effect except Data update.
- Reset in WAIT or ERR: returns to IDLE next cycle, counters cleared.

## Test plan
- Reset then idle: Instr=0x00000013, op=7'h13, OldPC=0, fetch_err=0, Stall=0 with IRWrite=0.
- Zero-wait fetch: PC=0x100, ReadData=0x00500093, IRWrite=1, mem_ready=1, PCWrite_in=1 → PCWrite=1, next cycle Instr=0x00500093, OldPC=0x100, rd=1, fetch_cnt=1.
- 3-wait fetch: mem_ready low 3 cycles → Stall=1 and PCWrite=0 for 3 cycles, capture on 4th, stall_cnt=3, fetch_cnt=1.
- Timeout (TIMEOUT=16): mem_ready low 16 cycles → fetch_err=1, Stall=1 permanently, later mem_ready ignored, Instr unchanged; reset clears all.
- IRWrite dropped in WAIT → IDLE, Instr unchanged, Stall=0.
- Counter saturation (CNTW=4): 20 zero-wait fetches → fetch_cnt=4'hF.
